// File: rtl/hamming_counter_scrub.sv
// Free-running up-counter protected by per-nibble Hamming(7,4) SEC parity,
// with load, idle-time scrubbing (check + in-place correction) and fault injection.
module hamming_counter_scrub #(
  parameter int WIDTH          = 128,
  parameter int SCRUB_INTERVAL = 16,
  parameter int ERRCNT_W       = 8,
  localparam int BLOCKS        = WIDTH / 4,
  localparam int PAR_BITS      = 3 * BLOCKS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                scrub_req,
  input  logic                inject_en,
  input  logic [WIDTH-1:0]    inject_data,
  input  logic [PAR_BITS-1:0] inject_par,
  output logic [WIDTH-1:0]    counter,
  output logic [PAR_BITS-1:0] parity,
  output logic                busy,
  output logic                err_corrected,
  output logic [BLOCKS-1:0]   err_block_mask,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int TMR_W = (SCRUB_INTERVAL > 2) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_ENCODE, S_CHECK, S_CORRECT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_counter, w_counter_nxt;
  logic [PAR_BITS-1:0] r_parity, w_parity_nxt;
  logic [PAR_BITS-1:0] r_syn, w_syn_nxt, w_syn_calc;
  logic [TMR_W-1:0]    r_timer, w_timer_nxt;
  logic [BLOCKS-1:0]   r_mask, w_mask_nxt;
  logic [ERRCNT_W-1:0] r_errcnt, w_errcnt_nxt;
  logic                r_errpulse, w_errpulse_nxt;

  function automatic logic [PAR_BITS-1:0] f_encode(input logic [WIDTH-1:0] d);
    logic [PAR_BITS-1:0] p;
    p = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      p[3*i+2] = d[4*i] ^ d[4*i+2] ^ d[4*i+3];
      p[3*i+1] = d[4*i] ^ d[4*i+1] ^ d[4*i+3];
      p[3*i+0] = d[4*i] ^ d[4*i+1] ^ d[4*i+2];
    end
    return p;
  endfunction

  assign w_syn_calc = r_parity ^ f_encode(r_counter);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_counter_nxt  = r_counter;
    w_parity_nxt   = r_parity;
    w_syn_nxt      = r_syn;
    w_timer_nxt    = '0;
    w_mask_nxt     = r_mask;
    w_errcnt_nxt   = r_errcnt;
    w_errpulse_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = r_timer;
        if (load) begin
          w_counter_nxt = load_value;
          w_state_nxt   = S_ENCODE;
          w_timer_nxt   = '0;
        end else if (enable) begin
          w_counter_nxt = r_counter + WIDTH'(1);
          w_state_nxt   = S_COUNT;
          w_timer_nxt   = '0;
        end else if (inject_en) begin
          // Faults land directly in the stored state; parity is deliberately not refreshed.
          w_counter_nxt = r_counter ^ inject_data;
          w_parity_nxt  = r_parity ^ inject_par;
        end else if (scrub_req || (r_timer == TMR_LAST)) begin
          w_state_nxt = S_CHECK;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_COUNT: begin
        if (load) begin
          w_counter_nxt = load_value;
          w_state_nxt   = S_ENCODE;
        end else if (enable) begin
          w_counter_nxt = r_counter + WIDTH'(1);
        end else begin
          w_state_nxt = S_ENCODE;
        end
      end
      S_ENCODE: begin
        w_parity_nxt = f_encode(r_counter);
        w_state_nxt  = S_IDLE;
      end
      S_CHECK: begin
        w_syn_nxt   = w_syn_calc;
        w_state_nxt = (|w_syn_calc) ? S_CORRECT : S_IDLE;
      end
      S_CORRECT: begin
        for (int i = 0; i < BLOCKS; i++) begin
          unique case (r_syn[3*i +: 3])
            3'b111:  w_counter_nxt[4*i+0] = ~r_counter[4*i+0];
            3'b011:  w_counter_nxt[4*i+1] = ~r_counter[4*i+1];
            3'b101:  w_counter_nxt[4*i+2] = ~r_counter[4*i+2];
            3'b110:  w_counter_nxt[4*i+3] = ~r_counter[4*i+3];
            3'b001:  w_parity_nxt[3*i+0]  = ~r_parity[3*i+0];
            3'b010:  w_parity_nxt[3*i+1]  = ~r_parity[3*i+1];
            3'b100:  w_parity_nxt[3*i+2]  = ~r_parity[3*i+2];
            default: ;
          endcase
          w_mask_nxt[i] = |r_syn[3*i +: 3];
        end
        if (r_errcnt != '1) w_errcnt_nxt = r_errcnt + ERRCNT_W'(1);
        w_errpulse_nxt = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_counter  <= '0;
      r_parity   <= '0;
      r_syn      <= '0;
      r_timer    <= '0;
      r_mask     <= '0;
      r_errcnt   <= '0;
      r_errpulse <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_counter  <= w_counter_nxt;
      r_parity   <= w_parity_nxt;
      r_syn      <= w_syn_nxt;
      r_timer    <= w_timer_nxt;
      r_mask     <= w_mask_nxt;
      r_errcnt   <= w_errcnt_nxt;
      r_errpulse <= w_errpulse_nxt;
    end
  end

  assign counter        = r_counter;
  assign parity         = r_parity;
  assign busy           = (r_state == S_ENCODE) || (r_state == S_CHECK) || (r_state == S_CORRECT);
  assign err_corrected  = r_errpulse;
  assign err_block_mask = r_mask;
  assign err_count      = r_errcnt;

endmodule

// File: doc/hamming_counter_scrub.md
Name: hamming_counter_scrub

Overview:
- Free-running up-counter of parametrised width, protected by per-nibble Hamming(7,4) SEC parity.
- Parity is encoded when counting stops. While idle, the counter state is periodically scrubbed: syndrome check, then in-place single-bit correction of data or parity per block.
- Successor to the fixed 128-bit protected counter. Adds load, a scrub FSM, forced scrub, a fault-injection port for verification, and error status/statistics.

Parameters:
- WIDTH, 128, counter width; must be a multiple of 4 and ≥4.
- BLOCKS, WIDTH/4, derived; number of 4-bit protected blocks.
- PAR_BITS, 3*BLOCKS, derived; total parity bits.
- SCRUB_INTERVAL, 16, IDLE cycles between automatic scrubs; must be ≥2.
- ERRCNT_W, 8, width of the saturating corrected-event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  count request; counter increments by 1 per cycle while high and accepted.
- load  in  1  load request; priority over enable.
- load_value  in  WIDTH  value written to the counter on an accepted load.
- scrub_req  in  1  single-cycle request to force an immediate scrub.
- inject_en  in  1  fault-injection strobe.
- inject_data  in  WIDTH  XOR mask applied to the counter on an accepted inject.
- inject_par  in  PAR_BITS  XOR mask applied to the parity on an accepted inject.
- counter  out  WIDTH  current counter value (register output).
- parity  out  PAR_BITS  stored parity (register output).
- busy  out  1  high in ENCODE, CHECK and CORRECT.
- err_corrected  out  1  one-cycle pulse after a correction.
- err_block_mask  out  BLOCKS  bit i set if block i was corrected in the last CORRECT.
- err_count  out  ERRCNT_W  number of CORRECT visits, saturating at all-ones.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - counter=0, parity=0, busy=0, err_corrected=0, err_block_mask=0, err_count=0, scrub timer=0, syndrome register=0.
  - Reset mid-operation aborts any state immediately. Parity 0 is consistent with counter 0.
- Encoding, block i with d=counter[4i+3:4i]:
  - p[3i+2]=d0^d2^d3
  - p[3i+1]=d0^d1^d3
  - p[3i+0]=d0^d1^d2
- Syndrome s_i = stored p_i XOR recomputed p_i, written {s2,s1,s0}. Decode table:
  - 111 → flip d0
  - 011 → flip d1
  - 101 → flip d2
  - 110 → flip d3
  - 001 / 010 / 100 → flip p0 / p1 / p2
  - 000 → no change
- Error model: correction is SEC only. Two errors in one block are miscorrected; this is accepted behaviour. Blocks are independent, so one error per block in several blocks is fully corrected in a single CORRECT.
- FSM states: IDLE, COUNT, ENCODE, CHECK, CORRECT.
  - IDLE:
    - load → counter<=load_value, go to ENCODE.
    - Else enable → counter<=counter+1, go to COUNT.
    - Else inject_en → counter^=inject_data, parity^=inject_par, stay in IDLE; no re-encode.
    - Else scrub_req, or scrub timer == SCRUB_INTERVAL-1 → go to CHECK.
    - Else timer increments.
    - Timer clears on every exit from IDLE.
  - COUNT:
    - load → counter<=load_value, go to ENCODE.
    - Else enable → counter+1, wrapping all-ones to 0.
    - Else (enable low) → counter holds, go to ENCODE.
    - inject_en and scrub_req are ignored.
  - ENCODE: parity<=encode(counter), go to IDLE. Inputs are ignored.
  - CHECK:
    - Syndrome register <= per-block syndrome.
    - Any nonzero block → CORRECT; all zero → IDLE.
    - Inputs are ignored.
  - CORRECT:
    - Apply the decode table to every block using the registered syndrome.
    - err_block_mask<=per-block (s≠0); err_count+1 (saturating); err_corrected<=1 for the next cycle only.
    - Go to IDLE. Inputs are ignored.
- Requests while busy: load, enable, scrub_req and inject_en are not queued. A held enable or load is accepted on the first IDLE cycle.
- Latency:
  - enable falling → parity valid 2 edges after the last increment (COUNT→ENCODE→IDLE).
  - scrub_req → corrected data visible 2 edges after acceptance (CHECK, CORRECT).
- Simultaneous events in IDLE are resolved by the priority load > enable > inject_en > scrub. The automatic scrub yields to all of these.
- Counter wraps modulo 2^WIDTH without a flag.

Test Plan:
- Reset, then enable high 10 cycles → counter=10. Enable low → busy=1 one cycle (ENCODE); parity[2:0]=3'b101 for block0 d=4'b1010; upper blocks parity 0.
- load=1, load_value=all-ones, then enable 1 cycle → counter wraps to 0; after ENCODE, parity=0.
- counter=0x5 (WIDTH=128), inject_data bit 2, then scrub_req → CHECK, CORRECT; counter back to 0x5; err_corrected pulse 1 cycle; err_block_mask=1; err_count=1.
- Inject parity bit 1 (block 0) and data bit 4*31+3 (block 31) in one strobe, then scrub → both repaired in one CORRECT; err_block_mask bits 0 and 31 set; err_count increments by 1.
- No inject, idle 3×SCRUB_INTERVAL cycles → exactly 3 CHECK visits, no CORRECT, err_count unchanged. Force err_count to saturate by 256 scrubbed errors (ERRCNT_W=8) → holds at 255.
- Assert rst during CORRECT → all outputs 0 asynchronously; state IDLE; no err_corrected pulse after release.
